ex_muldiv_ctrl: RTL
===================

# ex_muldiv_ctrl

Sequencing controller for an iterative RV32M multiply/divide unit attached to the EX stage. When EX holds an M-extension instruction, it latches the operands and runs a 32-iteration shift-add multiply or restoring divide. It holds `stall` high so IF/ID/EX freeze until the result is ready, then presents the 32-bit result for one cycle alongside the EX ALU result.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `ITER`, 32: iterations per operation. Must equal `XLEN`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: EX stage holds an M-extension instruction (opcode 0110011, funct7 0000001).
- `funct3` in 3: instruction [14:12]. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `readData1` in 32: rs1 operand, forwarded value.
- `readData2` in 32: rs2 operand, forwarded value.
- `flush` in 1: kill any in-flight operation (branch taken or pipeline flush).
- `stall` out 1: freeze PC, IF/ID and ID/EX registers.
- `result_valid` out 1: `result` is valid this cycle.
- `result` out 32: operation result, muxed into EX/MEM in place of the ALU result.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - `req_valid`=1 → latch `funct3`, operand magnitudes and sign flags; clear the iteration counter.
  - Next state: MUL for funct3[2]=0, DIV for funct3[2]=1.
  - Special cases go straight to DONE with the result preloaded:
    - Divide by zero (`readData2`=0): DIV/DIVU → 0xFFFFFFFF; REM/REMU → `readData1`.
    - Signed overflow (DIV/REM, `readData1`=0x80000000, `readData2`=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Signed operands are converted to magnitudes; the sign is applied at the end.
- MUL: one shift-add step per cycle on a 64-bit product register; counter 0..31; leave after counter=31.
  - Product is negated if the operand signs differ.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); counter 0..31.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- DONE: registered `result` valid, `result_valid`=1; next state IDLE unconditionally. `req_valid` is ignored in DONE because the pipeline advances this cycle.
- `stall` is combinational and equals `~flush & ((IDLE & req_valid) | MUL | DIV)`.
- Priority: `rst` > `flush` > normal operation.
  - `flush` in any state → IDLE next cycle; `result_valid` stays 0; no result is delivered.
  - A `flush` in the same cycle as an IDLE request prevents acceptance.
- `readData1`, `readData2` and `funct3` are sampled only in the accepting cycle; later changes have no effect.

## Timing
- Reset values: state IDLE, counter 0, `result` 0, `result_valid` 0. `stall` is 0 unless `req_valid` is high in IDLE.
- Normal op accepted at cycle T:
  - MUL or DIV state in cycles T+1..T+32.
  - DONE in cycle T+33.
  - `stall` high T..T+32, low at T+33.
  - `result_valid` high only at T+33.
- Special-case op accepted at T: DONE at T+1, `stall` high at T only, `result_valid` at T+1.
- Back-to-back ops: a new request is accepted at T+34 at the earliest (IDLE after DONE). Throughput is one op per 34 cycles (2 cycles for special cases).
- `rst` mid-operation: all state returns to reset values on the next edge.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), accepted at T → `stall` high T..T+32; `result`=0xFFFFFFEB with `result_valid` at T+33 only.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF at T+1; REM 5/0 → 5 at T+1. Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. Each case has `stall` high for one cycle.
- `flush` at T+10 of a DIV → `stall` low at T+10, state IDLE at T+11, no `result_valid`. A new MUL 3×4 at T+12 → 12 at T+45.
- `rst` at T+5 of a MUL → all outputs at reset values from T+6. Changing `readData1`/`readData2` after acceptance does not alter the result.

Source files
------------

// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer for the EX stage: one shift-add or
// restoring-divide step per cycle, stalling the front of the pipe until done.
module ex_muldiv_ctrl #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] readData1,
    input  logic [XLEN-1:0] readData2,
    input  logic            flush,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [XLEN-1:0]     b_mag_q, b_mag_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;

    logic                a_sgn, b_sgn;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, prod_fix;
    logic [XLEN:0]       div_trial;
    logic [2*XLEN-1:0]   div_next;
    logic [XLEN-1:0]     quot_fix, rem_fix;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // acc holds {hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        prod_fix  = (neg_a_q ^ neg_b_q) ? (~mul_next + 1'b1) : mul_next;
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_mag_q};
        div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        quot_fix  = apply_sign(div_next[XLEN-1:0], neg_a_q ^ neg_b_q);
        rem_fix   = apply_sign(div_next[2*XLEN-1:XLEN], neg_a_q);
        a_sgn     = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_sgn     = funct3[2] ? ~funct3[0] : ~funct3[1];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        funct3_d = funct3_q;
        b_mag_d  = b_mag_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        acc_d    = acc_q;
        stall    = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    funct3_d = funct3;
                    neg_a_d  = a_sgn & readData1[XLEN-1];
                    neg_b_d  = b_sgn & readData2[XLEN-1];
                    acc_d    = {{XLEN{1'b0}}, magnitude(readData1, a_sgn)};
                    b_mag_d  = magnitude(readData2, b_sgn);
                    cnt_d    = '0;
                    state_d  = funct3[2] ? S_DIV : S_MUL;
                    if (funct3[2] && readData2 == '0) begin
                        state_d  = S_DONE;
                        result_d = funct3[1] ? readData1 : '1;
                    end else if (funct3[2] && !funct3[0] &&
                                 readData1 == {1'b1, {(XLEN-1){1'b0}}} && readData2 == '1) begin
                        state_d  = S_DONE;
                        result_d = funct3[1] ? '0 : readData1;
                    end
                end
            end
            S_MUL: begin
                stall = 1'b1;
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER-1)) begin
                    state_d  = S_DONE;
                    result_d = (funct3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                        : prod_fix[2*XLEN-1:XLEN];
                end
            end
            S_DIV: begin
                stall = 1'b1;
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER-1)) begin
                    state_d  = S_DONE;
                    result_d = funct3_q[1] ? rem_fix : quot_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush kills the op outright, including one being accepted this cycle
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            stall    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        funct3_q <= funct3_d;
        b_mag_q  <= b_mag_d;
        neg_a_q  <= neg_a_d;
        neg_b_q  <= neg_b_d;
        acc_q    <= acc_d;
    end

    assign result_valid = (state_q == S_DONE);
    assign result       = result_q;

endmodule
